// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and BRAM port bundle for mem_access_ctrl
// master = CPU side plus BRAM data return, slave = the controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store controller with sub-word extract and read-modify-write
// Optional misalignment faulting: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [31:0]       wbuf;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        lane;
  logic              misaligned;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign req_addr = bus.req_addr;
  // mem_addr only changes on acceptance, so it still holds this request's address
  assign lane = bus.mem_addr[1:0];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'b01) && req_addr[0]) ||
                      (bus.req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    rd_byte  = bus.mem_rdata[{lane, 3'b000} +: 8];
    rd_half  = lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val = bus.mem_rdata;
    merged   = bus.mem_rdata;
    case (size_q)
      2'b00: begin
        load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
        merged[{lane, 3'b000} +: 8] = wbuf[7:0];
      end
      2'b01: begin
        load_val = {{16{signed_q & rd_half[15]}}, rd_half};
        if (lane[1]) merged[31:16] = wbuf[15:0];
        else         merged[15:0]  = wbuf[15:0];
      end
      default: begin
        load_val = bus.mem_rdata;
        merged   = wbuf;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'b00;
      wbuf           <= 32'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_fault <= 1'b0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= 32'd0;
    end else begin
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q           <= bus.req_we;
            signed_q       <= bus.req_signed;
            size_q         <= bus.req_size;
            wbuf           <= bus.req_wdata;
            bus.req_ready  <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_fault <= 1'b0;
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
            end else begin
              bus.mem_addr <= req_addr;
              if (bus.req_we && bus.req_size[1]) begin
                state         <= WR;
                bus.mem_wr_en <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
              end else begin
                state         <= RD;
                bus.mem_rd_en <= 1'b1;
              end
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (we_q) begin
            wbuf          <= merged;
            bus.mem_wdata <= merged;
            bus.mem_wr_en <= 1'b1;
            state         <= WR;
          end else begin
            bus.resp_rdata <= load_val;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WR: begin
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl against a word-array reference model
// Build with or without MEM_ACCESS_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] bram    [0:255];
  logic [31:0] ref_mem [0:255];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int acc_cyc = -1, exp_cyc = -1, exp_rd = -1, exp_wr = -1;
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0] exp_wdata, exp_rdata;
  logic exp_fault;
  int resp_count = 0;
  int got_cyc = 0;
  logic [31:0] got_rdata;
  logic got_fault;
  int last_acc = 0;
  logic busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr_en) bram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= bram[bus.mem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no event within bound (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_rd_en", bus.mem_rd_en, 0);
      check("rst_wr_en", bus.mem_wr_en, 0);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_resp_fault", bus.resp_fault, 0);
    end else begin
      busy = (acc_cyc >= 0) && (cyc >= acc_cyc) && (cyc <= exp_cyc);
      check("req_ready", bus.req_ready, !busy);
      check("resp_valid", bus.resp_valid, cyc == exp_cyc);
      check("mem_rd_en", bus.mem_rd_en, cyc == exp_rd);
      check("mem_wr_en", bus.mem_wr_en, cyc == exp_wr);
      if (bus.mem_rd_en || bus.mem_wr_en) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      if (bus.mem_wr_en) check("mem_wdata", bus.mem_wdata, exp_wdata);
      if (bus.resp_valid) begin
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check("resp_fault", bus.resp_fault, exp_fault);
        got_rdata  = bus.resp_rdata;
        got_fault  = bus.resp_fault;
        got_cyc    = cyc;
        resp_count = resp_count + 1;
      end
    end
  end

  // Expected outcome of one request accepted at edge a (cycle T = a-1).
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata, input int a);
    int w, shift;
    logic [31:0] mask, old, v;
    logic fault;
    w = int'(addr[9:2]);
    old = ref_mem[w];
    fault = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    fault = ((size == 2'b01) && addr[0]) || ((size >= 2'b10) && (addr[1:0] != 2'b00));
`endif
    if (size >= 2'b10) begin shift = 0; mask = 32'hFFFF_FFFF; end
    else if (size == 2'b01) begin shift = int'(addr[1]) * 16; mask = 32'h0000_FFFF; end
    else begin shift = int'(addr[1:0]) * 8; mask = 32'h0000_00FF; end
    acc_cyc = a; exp_addr = addr; exp_fault = fault; exp_rdata = 0;
    exp_rd = -1; exp_wr = -1;
    if (fault) begin
      exp_cyc = a;
    end else if (!we) begin
      v = (old >> shift) & mask;
      if (sgn && size < 2'b10 && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
      exp_rdata = v; exp_rd = a; exp_cyc = a + 2;
    end else if (size >= 2'b10) begin
      exp_wdata = wdata; exp_wr = a; exp_cyc = a + 1; ref_mem[w] = wdata;
    end else begin
      v = (old & ~(mask << shift)) | ((wdata & mask) << shift);
      exp_wdata = v; exp_rd = a; exp_wr = a + 2; exp_cyc = a + 3; ref_mem[w] = v;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge (or the response).
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input bit keep_valid, input bit wait_resp,
                       output logic [31:0] rdata, output logic fault, output int lat);
    int n, start;
    rdata = 0; fault = 0; lat = -1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    model(we, size, sgn, addr, wdata, cyc + 1);
    start = resp_count;
    @(posedge clk); #1;
    if (!keep_valid) bus.req_valid = 1'b0;
    if (wait_resp) begin
      n = 0;
      while (resp_count == start && n < 10) begin @(posedge clk); #1; n++; end
      if (resp_count == start) fail_now("resp_timeout");
      else begin rdata = got_rdata; fault = got_fault; lat = got_cyc - (last_acc - 1); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic flt;
    int lat, a1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++)
      issue(1, 2'b10, 0, ADDR_W'(i * 4), $urandom, 0, 0, rd, flt, lat);
    repeat (6) @(posedge clk); #1;

    issue(1, 2'b10, 0, 16'h0010, 32'hDEAD_BEEF, 0, 1, rd, flt, lat);
    check("lat_word_store", lat, 2);
    issue(0, 2'b10, 0, 16'h0010, 0, 0, 1, rd, flt, lat);
    check("lit_word_load", rd, 32'hDEAD_BEEF);
    check("lat_load", lat, 3);

    issue(1, 2'b10, 0, 16'h0020, 32'h8070_F0A5, 0, 1, rd, flt, lat);
    issue(0, 2'b00, 1, 16'h0021, 0, 0, 1, rd, flt, lat);
    check("lit_lb_signed", rd, 32'hFFFF_FFF0);
    issue(0, 2'b01, 0, 16'h0022, 0, 0, 1, rd, flt, lat);
    check("lit_lhu", rd, 32'h0000_8070);
    issue(0, 2'b01, 1, 16'h0022, 0, 0, 1, rd, flt, lat);
    check("lit_lh_signed", rd, 32'hFFFF_8070);
    issue(1, 2'b00, 1, 16'h0023, 32'hABCD_EF12, 0, 1, rd, flt, lat);
    check("lat_byte_store", lat, 4);
    check("lit_store_rdata", rd, 32'h0);
    issue(0, 2'b10, 0, 16'h0020, 0, 0, 1, rd, flt, lat);
    check("lit_after_sb", rd, 32'h1270_F0A5);

    issue(1, 2'b10, 0, 16'h0040, 32'h55AA_55AA, 1, 0, rd, flt, lat);
    a1 = last_acc;
    issue(0, 2'b10, 0, 16'h0040, 0, 0, 1, rd, flt, lat);
    check("b2b_accept_gap", last_acc - a1, 3);
    check("b2b_load", rd, 32'h55AA_55AA);

    issue(1, 2'b10, 0, 16'h0004, 32'h1122_3344, 0, 1, rd, flt, lat);
    issue(0, 2'b10, 0, 16'h0006, 0, 0, 1, rd, flt, lat);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("lit_fault_flag", flt, 1);
    check("lit_fault_rdata", rd, 32'h0);
    check("lat_fault", lat, 1);
`else
    check("lit_misaligned_word", rd, 32'h1122_3344);
    check("lit_misaligned_fault", flt, 0);
    check("lat_misaligned", lat, 3);
`endif

    issue(1, 2'b10, 0, 16'h0030, 32'hCAFE_F00D, 0, 1, rd, flt, lat);
    issue(1, 2'b01, 0, 16'h0032, 32'h0000_BEEF, 0, 0, rd, flt, lat);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_cyc = -1; exp_cyc = -1; exp_rd = -1; exp_wr = -1;
    ref_mem[12] = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_ready", bus.req_ready, 1);
    check("abort_mem_word", bram[12], 32'hCAFE_F00D);
    @(posedge clk); #1;
    issue(0, 2'b10, 0, 16'h0030, 0, 0, 1, rd, flt, lat);
    check("abort_reload", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 1023)), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0), rd, flt, lat);
    bus.req_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    for (int i = 0; i < 256; i++) check("mem_word", bram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller between the CPU memory stage and the data `bram`. It accepts one load or store request at a time over a valid/ready handshake. It drives the BRAM's registered-read, word-addressed port, extracts and extends byte/halfword loads, and performs read-modify-write for byte/halfword stores. The result or acknowledge is returned as a one-cycle response pulse.

## Interface
- `ADDR_W`, 16, byte-address width; matches the BRAM `addr` width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle; a request is accepted when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `req_signed`  in  1  sign-extend byte/halfword loads.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores.
- `resp_fault`  out  1  misalignment fault (see Configuration).
- `mem_rd_en`, `mem_wr_en`  out  1  BRAM enables.
- `mem_addr`  out  ADDR_W  BRAM byte address.
- `mem_wdata`  out  32  BRAM write data.
- `mem_rdata`  in  32  BRAM `odata`; valid the cycle after `mem_rd_en`.

## Operation
- States: IDLE, RD, WAIT, WR, RESP. The reset state is IDLE.
- `req_ready` = 1 only in IDLE. Request fields are captured on acceptance; inputs are ignored thereafter.
- Transitions out of IDLE on accept:
  - Load, or sub-word store: go to RD.
  - Word store: go to WR.
- RD: `mem_rd_en` = 1; next state is WAIT.
- WAIT, for a load: extract the lane, extend it, register it into `resp_rdata`; next state is RESP.
- WAIT, for a sub-word store: merge the new lane into `mem_rdata`, register the result into the write buffer; next state is WR.
- WR: `mem_wr_en` = 1 and `mem_wdata` = write buffer. For a word store the write buffer is `req_wdata`. Next state is RESP.
- RESP: `resp_valid` = 1; next state is IDLE. There is no back-pressure on the response.
- `mem_addr` = captured address in RD and WR, and holds its value otherwise. Both enables are 0 outside RD and WR.
- Lane selection is little-endian:
  - Byte k = bits [8k+7:8k], with k = addr[1:0].
  - Halfword uses addr[1]: bits [15:0] or [31:16].
  - A word access ignores addr[1:0].
- Extension:
  - `req_signed` = 1 replicates the lane MSB.
  - Otherwise the result is zero-extended.
  - `req_signed` is ignored for word accesses and for stores.
- Sub-word store data comes from the low byte or halfword of `req_wdata`. All other lanes keep the value read from memory.

## Timing
- Accept at cycle T. `resp_valid` is asserted at:
  - Load: T+3.
  - Word store: T+2.
  - Sub-word store: T+4.
  - Faulted access: T+1.
- Next acceptance is possible in the cycle after RESP.
- Reset values: `req_ready` = 1, and all other outputs = 0 (`resp_rdata`, `resp_fault`, `resp_valid`, `mem_*`).
- Reset asserted mid-operation:
  - State returns to IDLE immediately.
  - Enables drop asynchronously.
  - The in-flight request is discarded and no response is issued.
  - A half-finished read-modify-write never writes.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is a fault.
  - A fault goes IDLE → RESP with no BRAM access: `resp_fault` = 1, `resp_rdata` = 0.
  - For stores, memory is unchanged.
- Not defined:
  - `resp_fault` is tied to 0.
  - Misaligned low bits are ignored as described in Operation.

## Test plan
- Word store 0xDEADBEEF @0x0010, then word load @0x0010 → `resp_rdata` = 0xDEADBEEF. Response pulses at T+2 (store) and T+3 (load).
- Memory word 0x8070_F0A5 @0x0020:
  - Signed byte load @0x0021 → 0xFFFF_FFF0.
  - Unsigned halfword load @0x0022 → 0x0000_8070.
  - Signed halfword load @0x0022 → 0xFFFF_8070.
- Byte store 0x12 @0x0023 over 0x8070_F0A5 → one RD then one WR. A word read then returns 0x1270_F0A5.
- Request held valid during a store → `req_ready` low from T+1 to RESP. The second request is accepted the cycle after the `resp_valid` pulse.
- Reset asserted in WAIT of a halfword store → no `mem_wr_en` pulse and no `resp_valid`; the memory word is unchanged; `req_ready` = 1 after release.
- With `MEM_ACCESS_ALIGN_CHECK_EN`:
  - Word load @0x0006 → `resp_fault` = 1 at T+1, no `mem_rd_en`.
  - Without the macro, the same load returns the word @0x0004.
